// File: rtl/controller_sseg_serial_writer_pkg.sv
// rtl/controller_sseg_serial_writer_pkg.sv - shared types and constants for the serial display writer
package controller_sseg_serial_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_HOLD     = 3'd4
    } state_t;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_OVERRUN = 3;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_FRAME_W = 16;

endpackage

// File: rtl/controller_sseg_serial_writer_if.sv
// rtl/controller_sseg_serial_writer_if.sv - PIO-side control/data and serial-side pins of the writer
interface controller_sseg_serial_writer_if
    import controller_sseg_serial_writer_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W
);
    logic [3:0]         ctrl;
    logic [FRAME_W-1:0] frame_data;
    logic               sclk;
    logic               mosi;
    logic               cs_n;
    logic [3:0]         status;

    modport master (output ctrl, frame_data, input sclk, mosi, cs_n, status);
    modport slave  (input ctrl, frame_data, output sclk, mosi, cs_n, status);
endinterface

// File: rtl/controller_sseg_sclk_tick.sv
// rtl/controller_sseg_sclk_tick.sv - one-cycle tick every CLK_DIV cycles, restartable
module controller_sseg_sclk_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/controller_sseg_serial_writer.sv
// rtl/controller_sseg_serial_writer.sv - shifts one PIO frame MSB-first to the display driver
module controller_sseg_serial_writer
    import controller_sseg_serial_writer_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int FRAME_W = DEF_FRAME_W
) (
    input  logic                          clk,
    input  logic                          reset,
    controller_sseg_serial_writer_if.slave bus
);
    localparam int BW = $clog2(FRAME_W + 1);

    state_t             state, state_next;
    logic [FRAME_W-1:0] sr, sr_d;
    logic [BW-1:0]      bit_cnt, bit_cnt_d;
    logic               cs_n_q, sclk_q, mosi_q;
    logic               cs_n_d, sclk_d, mosi_d;
    logic               done_q, aborted_q, overrun_q;
    logic               done_d, aborted_d, overrun_d;
    logic               ctrl0_q;
    logic               start_edge, abort, tick, restart, busy;
    logic [1:0]         ctrl_unused;
    logic [3:0]         status_w;

    assign ctrl_unused = bus.ctrl[3:2];
    assign start_edge  = bus.ctrl[CTRL_START] & ~ctrl0_q;
    assign abort       = bus.ctrl[CTRL_ABORT];
    assign busy        = (state != ST_IDLE);
    assign restart     = (state_next != state);

    controller_sseg_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            overrun_q <= 1'b0;
            ctrl0_q   <= 1'b1;
        end else begin
            state     <= state_next;
            sr        <= sr_d;
            bit_cnt   <= bit_cnt_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            overrun_q <= overrun_d;
            ctrl0_q   <= bus.ctrl[CTRL_START];
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_IDLE) begin
            if (start_edge && !abort) state_next = ST_SETUP;
        end else if (abort) begin
            state_next = ST_IDLE;
        end else if (tick) begin
            case (state)
                ST_SETUP:    state_next = ST_SHIFT_HI;
                ST_SHIFT_HI: state_next = (bit_cnt == BW'(1)) ? ST_HOLD : ST_SHIFT_LO;
                ST_SHIFT_LO: state_next = ST_SHIFT_HI;
                ST_HOLD:     state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    // Pin values are computed for the state being entered so they come straight off flops.
    always_comb begin
        sr_d      = sr;
        bit_cnt_d = bit_cnt;
        mosi_d    = mosi_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        overrun_d = overrun_q;
        cs_n_d    = (state_next == ST_IDLE);
        sclk_d    = (state_next == ST_SHIFT_HI);

        if (state == ST_IDLE && state_next == ST_SETUP) begin
            sr_d      = bus.frame_data;
            bit_cnt_d = BW'(FRAME_W);
            mosi_d    = bus.frame_data[FRAME_W-1];
            done_d    = 1'b0;
            aborted_d = 1'b0;
            overrun_d = 1'b0;
        end
        if (state == ST_SHIFT_HI && (state_next == ST_SHIFT_LO || state_next == ST_HOLD))
            bit_cnt_d = bit_cnt - BW'(1);
        if (state == ST_SHIFT_HI && state_next == ST_SHIFT_LO) begin
            sr_d   = sr << 1;
            mosi_d = sr[FRAME_W-2];
        end
        if (state == ST_HOLD && state_next == ST_IDLE && !abort) done_d = 1'b1;
        if (busy && abort)      aborted_d = 1'b1;
        if (busy && start_edge) overrun_d = 1'b1;
        if (state_next == ST_IDLE) mosi_d = 1'b0;
    end

    always_comb begin
        status_w               = '0;
        status_w[STAT_BUSY]    = busy;
        status_w[STAT_DONE]    = done_q;
        status_w[STAT_ABORTED] = aborted_q;
        status_w[STAT_OVERRUN] = overrun_q;
    end

    assign bus.status = status_w;
    assign bus.sclk   = sclk_q;
    assign bus.mosi   = mosi_q;
    assign bus.cs_n   = cs_n_q;
endmodule

// File: tb/tb_controller_sseg_serial_writer.sv
// tb/tb_controller_sseg_serial_writer.sv - self-checking bench for controller_sseg_serial_writer
module tb_controller_sseg_serial_writer;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    controller_sseg_serial_writer_if #(.FRAME_W(16)) bus_a ();
    controller_sseg_serial_writer_if #(.FRAME_W(8))  bus_b ();

    controller_sseg_serial_writer #(.CLK_DIV(4), .FRAME_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    controller_sseg_serial_writer #(.CLK_DIV(2), .FRAME_W(8)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    // Reference model: a frame is data MSB-first, one bit per sclk rise, cs_n low for CLK_DIV*(2*FRAME_W+1) cycles.
    function automatic int frame_len(int cdiv, int fw);
        return cdiv * (2 * fw + 1);
    endfunction

    int          a_falls = 0, a_frames = 0, a_rises_total = 0, a_low = 0, a_rises = 0;
    int          a_last_len = 0, a_last_rises = 0;
    logic [15:0] a_bits = '0, a_last_bits = '0;
    logic        a_cs_prev = 1'b1, a_sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!bus_a.cs_n && a_cs_prev) begin
            a_falls++; a_low = 0; a_rises = 0; a_bits = '0;
        end
        if (!bus_a.cs_n) a_low++;
        if (bus_a.sclk && !a_sclk_prev) begin
            a_rises_total++;
            if (!bus_a.cs_n) begin a_rises++; a_bits = {a_bits[14:0], bus_a.mosi}; end
        end
        if (bus_a.cs_n && !a_cs_prev) begin
            a_frames++; a_last_bits = a_bits; a_last_len = a_low; a_last_rises = a_rises;
        end
        a_cs_prev   = bus_a.cs_n;
        a_sclk_prev = bus_a.sclk;
    end

    int         b_frames = 0, b_low = 0, b_rises = 0, b_last_len = 0, b_last_rises = 0;
    logic [7:0] b_bits = '0, b_last_bits = '0;
    logic       b_cs_prev = 1'b1, b_sclk_prev = 1'b0;

    always @(negedge clk) begin
        if (!bus_b.cs_n && b_cs_prev) begin b_low = 0; b_rises = 0; b_bits = '0; end
        if (!bus_b.cs_n) b_low++;
        if (bus_b.sclk && !b_sclk_prev && !bus_b.cs_n) begin
            b_rises++; b_bits = {b_bits[6:0], bus_b.mosi};
        end
        if (bus_b.cs_n && !b_cs_prev) begin
            b_frames++; b_last_bits = b_bits; b_last_len = b_low; b_last_rises = b_rises;
        end
        b_cs_prev   = bus_b.cs_n;
        b_sclk_prev = bus_b.sclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [15:0] d, input logic [3:0] c);
        bus_a.frame_data = d;
        bus_a.ctrl = c;
        tick_n(1);
        bus_a.ctrl = 4'b0000;
        bus_a.frame_data = ~d;
    endtask

    task automatic wait_frame_a(input int base, input string name);
        int k = 0;
        while (a_frames == base && k < 1000) begin @(negedge clk); #1; k++; end
        check({name, " frame seen"}, 32'(a_frames != base), 32'd1);
    endtask

    task automatic wait_frame_b(input int base, input string name);
        int k = 0;
        while (b_frames == base && k < 1000) begin @(negedge clk); #1; k++; end
        check({name, " frame seen"}, 32'(b_frames != base), 32'd1);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  ctrl;
        bit          exp_frame;
        logic [3:0]  exp_status;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;
        logic [15:0] d16;
        logic [7:0]  d8;
        logic [1:0]  rsv;

        vecs[0] = '{16'hA53C, 4'b0001, 1'b1, 4'b0010};
        vecs[1] = '{16'h0000, 4'b0001, 1'b1, 4'b0010};
        vecs[2] = '{16'hFFFF, 4'b1101, 1'b1, 4'b0010};
        vecs[3] = '{16'h8001, 4'b0011, 1'b0, 4'b0010};
        vecs[4] = '{16'h5AA5, 4'b0001, 1'b1, 4'b0010};

        reset = 1'b1;
        bus_a.ctrl = '0; bus_a.frame_data = '0;
        bus_b.ctrl = '0; bus_b.frame_data = '0;
        tick_n(3);
        check("rst cs_n", 32'(bus_a.cs_n), 32'd1);
        check("rst sclk", 32'(bus_a.sclk), 32'd0);
        check("rst mosi", 32'(bus_a.mosi), 32'd0);
        check("rst status", 32'(bus_a.status), 32'd0);
        check("rst b status", 32'(bus_b.status), 32'd0);
        reset = 1'b0;
        tick_n(2);

        // cs_n falls exactly one cycle after the start edge
        bus_a.frame_data = 16'h0F0F;
        bus_a.ctrl = 4'b0001;
        base = a_frames;
        @(negedge clk); #1;
        check("cs_n before edge", 32'(bus_a.cs_n), 32'd1);
        @(negedge clk); #1;
        check("cs_n after edge", 32'(bus_a.cs_n), 32'd0);
        check("busy in frame", 32'(bus_a.status[0]), 32'd1);
        bus_a.ctrl = 4'b0000;
        wait_frame_a(base, "first");
        check("first bits", 32'(a_last_bits), 32'h0F0F);
        tick_n(2);

        foreach (vecs[i]) begin
            base = a_frames;
            pulse_a(vecs[i].data, vecs[i].ctrl);
            if (vecs[i].exp_frame) begin
                wait_frame_a(base, $sformatf("vec%0d", i));
                check($sformatf("vec%0d bits", i), 32'(a_last_bits), 32'(vecs[i].data));
                check($sformatf("vec%0d len", i), 32'(a_last_len), 32'(frame_len(4, 16)));
                check($sformatf("vec%0d rises", i), 32'(a_last_rises), 32'd16);
            end else begin
                tick_n(200);
                check($sformatf("vec%0d no frame", i), 32'(a_frames - base), 32'd0);
            end
            check($sformatf("vec%0d status", i), 32'(bus_a.status), 32'(vecs[i].exp_status));
            tick_n(3);
        end

        for (int i = 0; i < 6; i++) begin
            d16 = 16'($urandom);
            rsv = 2'($urandom);
            base = a_frames;
            pulse_a(d16, {rsv, 2'b01});
            wait_frame_a(base, "rand_a");
            check($sformatf("rand_a%0d bits", i), 32'(a_last_bits), 32'(d16));
            check($sformatf("rand_a%0d len", i), 32'(a_last_len), 32'(frame_len(4, 16)));
            tick_n(1 + int'($urandom_range(0, 5)));
        end

        // level held high must not retrigger
        base = a_frames;
        bus_a.frame_data = 16'h3C3C;
        bus_a.ctrl = 4'b0001;
        tick_n(300);
        bus_a.ctrl = 4'b0000;
        tick_n(50);
        check("held start frames", 32'(a_frames - base), 32'd1);

        // second start mid-frame: overrun flagged, frame intact
        base = a_frames;
        pulse_a(16'hA53C, 4'b0001);
        tick_n(40);
        bus_a.frame_data = 16'h1234;
        bus_a.ctrl = 4'b0001;
        tick_n(1);
        bus_a.ctrl = 4'b0000;
        wait_frame_a(base, "overrun");
        check("overrun bits", 32'(a_last_bits), 32'hA53C);
        check("overrun len", 32'(a_last_len), 32'(frame_len(4, 16)));
        check("overrun status", 32'(bus_a.status), 32'b1010);
        tick_n(3);

        // abort mid-frame
        pulse_a(16'hFFFF, 4'b0001);
        tick_n(50);
        bus_a.ctrl = 4'b0010;
        tick_n(1);
        check("abort cs_n", 32'(bus_a.cs_n), 32'd1);
        check("abort sclk", 32'(bus_a.sclk), 32'd0);
        check("abort mosi", 32'(bus_a.mosi), 32'd0);
        check("abort status", 32'(bus_a.status), 32'b0100);
        bus_a.ctrl = 4'b0000;
        base = a_rises_total;
        tick_n(200);
        check("abort no sclk", 32'(a_rises_total - base), 32'd0);
        check("abort sticky", 32'(bus_a.status), 32'b0100);

        // reset mid-frame with start held across release
        pulse_a(16'hC3C3, 4'b0001);
        tick_n(20);
        reset = 1'b1;
        bus_a.ctrl = 4'b0001;
        tick_n(2);
        reset = 1'b0;
        tick_n(1);
        check("rst mid cs_n", 32'(bus_a.cs_n), 32'd1);
        check("rst mid sclk", 32'(bus_a.sclk), 32'd0);
        check("rst mid mosi", 32'(bus_a.mosi), 32'd0);
        check("rst mid status", 32'(bus_a.status), 32'd0);
        base = a_falls;
        tick_n(200);
        check("rst held no frame", 32'(a_falls - base), 32'd0);
        bus_a.ctrl = 4'b0000;
        tick_n(1);
        base = a_frames;
        pulse_a(16'h6E91, 4'b0001);
        wait_frame_a(base, "post reset");
        check("post reset bits", 32'(a_last_bits), 32'h6E91);

        // small configuration
        base = b_frames;
        bus_b.frame_data = 8'hFF;
        bus_b.ctrl = 4'b0001;
        tick_n(1);
        bus_b.ctrl = 4'b0000;
        bus_b.frame_data = 8'h00;
        wait_frame_b(base, "b_ff");
        check("b_ff len", 32'(b_last_len), 32'(frame_len(2, 8)));
        check("b_ff bits", 32'(b_last_bits), 32'hFF);
        check("b_ff rises", 32'(b_last_rises), 32'd8);
        check("b_ff status", 32'(bus_b.status), 32'b0010);

        for (int i = 0; i < 6; i++) begin
            d8 = 8'($urandom);
            base = b_frames;
            bus_b.frame_data = d8;
            bus_b.ctrl = 4'b0001;
            tick_n(1);
            bus_b.ctrl = 4'b0000;
            bus_b.frame_data = ~d8;
            wait_frame_b(base, "rand_b");
            check($sformatf("rand_b%0d bits", i), 32'(b_last_bits), 32'(d8));
            check($sformatf("rand_b%0d len", i), 32'(b_last_len), 32'(frame_len(2, 8)));
            tick_n(1 + int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/controller_sseg_serial_writer.md
CONTROLLER_SSEG_SERIAL_WRITER -- requirements
Module: controller_sseg_serial_writer

Interface
REQ-001 Parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 2..255.
REQ-002 Parameter FRAME_W, default 16: serial frame length in bits.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 ctrl  input  4  control word from the write-control PIO: [0] start, [1] abort, [3:2] reserved and ignored.
REQ-007 frame_data  input  FRAME_W  digit address/segment frame from the data PIO; sampled only at an accepted start.
REQ-008 sclk  output  1  serial clock to the display driver; idles low.
REQ-009 mosi  output  1  serial data, MSB first.
REQ-010 cs_n  output  1  driver chip select, active low.
REQ-011 status  output  4  status word for the readback PIO: {overrun, aborted, done, busy}.

Function
REQ-012 Start event = ctrl[0] high in the current cycle and low in the previous cycle; a level held high SHALL NOT retrigger.
REQ-013 Abort = ctrl[1] level; evaluated every cycle.
REQ-014 FSM states: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD.
REQ-015 IDLE: on start without abort, frame_data is latched into the shift register, the bit counter is set to FRAME_W, done/aborted/overrun are cleared, and the next state is SETUP.
REQ-016 SETUP: cs_n=0, sclk=0, mosi=frame MSB; lasts CLK_DIV cycles, then SHIFT_HI.
REQ-017 SHIFT_HI: sclk=1 for CLK_DIV cycles; the bit counter decrements at exit; exit goes to SHIFT_LO if the counter is nonzero, else to HOLD.
REQ-018 SHIFT_LO: sclk=0 for CLK_DIV cycles; mosi advances to the next bit in the first cycle of SHIFT_LO (driver samples on rising sclk).
REQ-019 HOLD: cs_n=0, sclk=0 for CLK_DIV cycles; at exit, cs_n=1, done=1, and the next state is IDLE.
REQ-020 Timing: cs_n is asserted in the cycle after the start edge; the frame occupies exactly CLK_DIV*(2*FRAME_W+1) cycles from cs_n falling to cs_n rising (132 for defaults).
REQ-021 busy=1 in every non-IDLE state, combinationally from the state register.
REQ-022 A start edge while busy SHALL be ignored for data and SHALL set overrun=1; the current frame continues unaffected.
REQ-023 Abort while busy: in the next cycle cs_n=1, sclk=0, mosi=0, state=IDLE, aborted=1, done unchanged (0).
REQ-024 Start and abort in the same IDLE cycle: abort wins; no frame is sent and no flag changes.
REQ-025 done, aborted, and overrun are sticky until the next accepted start or reset.
REQ-026 In IDLE: cs_n=1, sclk=0, mosi=0.

Reset
REQ-027 Reset SHALL force: state=IDLE, cs_n=1, sclk=0, mosi=0, status=4'b0000, shift register=0, divider=0, and the ctrl[0] history register=1 (a ctrl[0] already high at reset release SHALL NOT start a frame).
REQ-028 Reset mid-frame SHALL take effect on the next clk edge regardless of state, with no completion of the frame.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the status bit index constants, and the default CLK_DIV/FRAME_W values.
REQ-030 One sub-module, controller_sseg_sclk_tick, SHALL generate a one-cycle tick every CLK_DIV cycles, restarted by the FSM on every state entry.
REQ-031 Outputs sclk, mosi, and cs_n SHALL be driven directly from registers, with no combinational path from ctrl.

Verification
REQ-032 frame_data=16'hA53C, pulse ctrl=4'b0001 -> cs_n low for 132 cycles, 16 sclk rises, bits sampled on rise = A53C MSB-first, status=4'b0010 after completion.
REQ-033 ctrl[0] held high for 300 cycles -> exactly one frame sent.
REQ-034 Second start edge at cycle 40 of a frame with frame_data=16'h1234 -> original frame sent intact, status=4'b1010 at end.
REQ-035 ctrl[1] asserted at cycle 50 of a frame -> cs_n=1 and sclk=0 the next cycle, status=4'b0100, and no further sclk edges.
REQ-036 Reset asserted at cycle 20 with ctrl[0]=1 held across reset release -> outputs idle, status=0, no frame until ctrl[0] falls and rises again.
REQ-037 CLK_DIV=2, FRAME_W=8, frame_data=8'hFF -> frame length 34 cycles, mosi=1 for all 8 rises.
